// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one shared full-adder slice adds two
// WIDTH-bit operands LSB first under a start/busy/done handshake.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             C_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic [WIDTH-1:0] s_nx;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic load;
    logic step;
    logic last;

    logic h1;
    logic c1;
    logic c2;
    logic s;
    logic c_nx;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        last     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == LAST) begin
                    last     = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Shared bit-slice: two cascaded half adders plus the sum shift-in
    always_comb begin
        h1   = a_sr[0] ^ b_sr[0];
        c1   = a_sr[0] & b_sr[0];
        s    = h1 ^ carry;
        c2   = h1 & carry;
        c_nx = c1 | c2;
        s_nx = s_sr >> 1;
        s_nx[WIDTH-1] = s;
    end

    // Operand/sum shift registers, carry and bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            a_sr  <= A;
            b_sr  <= B;
            s_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (step) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            s_sr  <= s_nx;
            carry <= c_nx;
            cnt   <= cnt + CW'(1);
        end
    end

    // Result registers update only when the last bit is processed
    always_ff @(posedge clk) begin
        if (rst) begin
            Sum   <= '0;
            C_out <= 1'b0;
        end else if (last) begin
            Sum   <= s_nx;
            C_out <= c_nx;
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance and a
// 1-bit instance sharing clock and reset.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int n_checks;
    int n_pass;

    serial_adder_ctrl #(.WIDTH(8)) u8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .A     (a8),
        .B     (b8),
        .busy  (busy8),
        .done  (done8),
        .Sum   (sum8),
        .C_out (cout8)
    );

    serial_adder_ctrl #(.WIDTH(1)) u1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .A     (a1),
        .B     (b1),
        .busy  (busy1),
        .done  (done1),
        .Sum   (sum1),
        .C_out (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start one 8-bit op and observe it; lat is the negedge index
    // (1 = first cycle after the start edge) at which done is seen.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output int nbusy, output int lat,
                        output int overlap,
                        output logic [7:0] s, output logic c);
        nbusy   = 0;
        lat     = 0;
        overlap = 0;
        s       = 'x;
        c       = 1'bx;
        @(negedge clk);
        a8     = a;
        b8     = b;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            if (busy8 && done8) overlap++;
            if (busy8) nbusy++;
            if (done8) begin
                lat = i;
                s   = sum8;
                c   = cout8;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run1(input logic a, input logic b,
                        output int nbusy, output int lat,
                        output logic s, output logic c);
        nbusy = 0;
        lat   = 0;
        s     = 1'bx;
        c     = 1'bx;
        @(negedge clk);
        a1     = a;
        b1     = b;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (busy1) nbusy++;
            if (done1) begin
                lat = i;
                s   = sum1[0];
                c   = cout1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy8, done8, sum8, cout8} !== 11'd0)
            $display("FAIL reset8 got busy=%b done=%b sum=%h cout=%b want 0/0/00/0",
                     busy8, done8, sum8, cout8);
        else n_pass++;
        n_checks++;
        if ({busy1, done1, sum1, cout1} !== 4'd0)
            $display("FAIL reset1 got busy=%b done=%b sum=%b cout=%b want 0/0/0/0",
                     busy1, done1, sum1, cout1);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int nb, lat, ov;
        logic [7:0] s;
        logic c;
        run8(8'd3, 8'd5, nb, lat, ov, s, c);
        n_checks++;
        if (nb !== 8) $display("FAIL basic_busy got %0d want 8", nb);
        else n_pass++;
        n_checks++;
        if (lat !== 9) $display("FAIL basic_lat got %0d want 9", lat);
        else n_pass++;
        n_checks++;
        if (ov !== 0) $display("FAIL basic_overlap got %0d want 0", ov);
        else n_pass++;
        n_checks++;
        if ({c, s} !== {1'b0, 8'd8})
            $display("FAIL basic_sum got %h/%b want 08/0", s, c);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done8 !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", done8);
        else n_pass++;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({cout8, sum8, busy8} !== {1'b0, 8'd8, 1'b0})
            $display("FAIL basic_hold got %h/%b busy=%b want 08/0 busy=0",
                     sum8, cout8, busy8);
        else n_pass++;
    endtask

    task automatic test_vectors();
        logic [7:0] va [3] = '{8'hFF, 8'hAA, 8'h80};
        logic [7:0] vb [3] = '{8'h01, 8'h55, 8'h80};
        logic [7:0] es [3] = '{8'h00, 8'hFF, 8'h00};
        logic       ec [3] = '{1'b1, 1'b0, 1'b1};
        int nb, lat, ov;
        logic [7:0] s;
        logic c;
        for (int k = 0; k < 3; k++) begin
            run8(va[k], vb[k], nb, lat, ov, s, c);
            n_checks++;
            if ({c, s} !== {ec[k], es[k]} || lat !== 9)
                $display("FAIL vec%0d got %h/%b lat=%0d want %h/%b lat=9",
                         k, s, c, lat, es[k], ec[k]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_run_ignore();
        int ndone, nbusy_after;
        @(negedge clk);
        a8     = 8'd10;
        b8     = 8'd20;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        ndone  = 0;
        for (int i = 1; i <= 25; i++) begin
            if (i == 1) begin
                a8 = 8'hFF;
                b8 = 8'hFF;
            end
            start8 = (i == 2) || (i == 5);
            if (done8) begin
                ndone++;
                n_checks++;
                if ({cout8, sum8} !== {1'b0, 8'd30})
                    $display("FAIL ignore_sum got %h/%b want 1e/0", sum8, cout8);
                else n_pass++;
            end
            @(negedge clk);
        end
        start8 = 1'b0;
        n_checks++;
        if (ndone !== 1) $display("FAIL ignore_ndone got %0d want 1", ndone);
        else n_pass++;
        nbusy_after = 0;
        repeat (5) begin
            if (busy8) nbusy_after++;
            @(negedge clk);
        end
        n_checks++;
        if (nbusy_after !== 0)
            $display("FAIL ignore_idle got busy cycles %0d want 0", nbusy_after);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int ndone, prev, gap_bad;
        @(negedge clk);
        a8      = 8'd1;
        b8      = 8'd1;
        start8  = 1'b1;
        ndone   = 0;
        prev    = 0;
        gap_bad = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done8) begin
                ndone++;
                if (prev != 0 && i - prev != 10) gap_bad++;
                if (prev == 0 && i != 9) gap_bad++;
                prev = i;
                n_checks++;
                if ({cout8, sum8} !== {1'b0, 8'd2})
                    $display("FAIL b2b_sum got %h/%b want 02/0", sum8, cout8);
                else n_pass++;
            end
        end
        start8 = 1'b0;
        n_checks++;
        if (ndone !== 3) $display("FAIL b2b_ndone got %0d want 3", ndone);
        else n_pass++;
        n_checks++;
        if (gap_bad !== 0) $display("FAIL b2b_spacing got %0d bad gaps want 0", gap_bad);
        else n_pass++;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_abort();
        int ndone, nb, lat, ov;
        logic [7:0] s;
        logic c;
        @(negedge clk);
        a8     = 8'd100;
        b8     = 8'd100;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({busy8, done8, sum8, cout8} !== 11'd0)
            $display("FAIL abort_state got busy=%b done=%b sum=%h cout=%b want 0/0/00/0",
                     busy8, done8, sum8, cout8);
        else n_pass++;
        ndone = 0;
        repeat (12) begin
            if (done8) ndone++;
            @(negedge clk);
        end
        n_checks++;
        if (ndone !== 0) $display("FAIL abort_nodone got %0d want 0", ndone);
        else n_pass++;
        run8(8'd7, 8'd9, nb, lat, ov, s, c);
        n_checks++;
        if ({c, s} !== {1'b0, 8'd16} || lat !== 9)
            $display("FAIL abort_next got %h/%b lat=%0d want 10/0 lat=9", s, c, lat);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_width1();
        logic ea [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic eb [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic es [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic ec [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int nb, lat;
        logic s, c;
        for (int k = 0; k < 4; k++) begin
            run1(ea[k], eb[k], nb, lat, s, c);
            n_checks++;
            if ({c, s} !== {ec[k], es[k]} || lat !== 2 || nb !== 1)
                $display("FAIL w1_%0d got s=%b c=%b lat=%0d busy=%0d want s=%b c=%b lat=2 busy=1",
                         k, s, c, lat, nb, es[k], ec[k]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        start8   = 1'b0;
        a8       = '0;
        b8       = '0;
        start1   = 1'b0;
        a1       = '0;
        b1       = '0;
        test_reset();
        test_basic();
        test_vectors();
        test_run_ignore();
        test_back_to_back();
        test_abort();
        test_width1();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller built around one shared bit-slice: two cascaded half adders form a full adder.
- Adds two WIDTH-bit operands one bit per clock, LSB first.
- Uses a start/busy/done handshake.
- Used where area matters more than latency. Sequences the bit-slice, holds the operands and carry between cycles, and presents a registered result.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- A  input  WIDTH  operand A; sampled on the accepted start edge.
- B  input  WIDTH  operand B; sampled on the accepted start edge.
- busy  output  1  high while an addition is in progress (RUN state).
- done  output  1  one-cycle pulse: Sum/C_out just updated.
- Sum  output  WIDTH  registered result A+B mod 2^WIDTH.
- C_out  output  1  registered carry out of bit WIDTH-1.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; busy=0, done=0, Sum=0, C_out=0; internal shift registers, carry and counter cleared. rst has priority over all other inputs. rst mid-operation aborts the addition with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 → load A into shift reg a_sr and B into b_sr; carry=0, bit counter=0; go to RUN.
  - start=0 → stay in IDLE.
- RUN (busy=1). At each edge:
  - Compute the slice from bit 0 of a_sr and b_sr plus carry: h1 = a^b, c1 = a&b; s = h1^carry, c2 = h1&carry.
  - carry <= c1|c2.
  - Shift s into s_sr from the MSB end; shift a_sr and b_sr right by 1.
  - Increment the counter.
- After the edge that processes bit WIDTH-1 (edge E0+WIDTH): Sum <= final s_sr contents, C_out <= final carry, go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle; next edge → IDLE.
- Latency: start accepted at edge E0 → busy high cycles E0+1..E0+WIDTH → done high in the cycle after edge E0+WIDTH. Earliest next accepted start is edge E0+WIDTH+2.
- start is ignored in RUN and DONE; start held high continuously produces back-to-back operations with one IDLE cycle between them.
- Changes on A/B after the start edge have no effect on the current operation.
- Sum/C_out change only on DONE entry or reset. Partial sums are never visible on outputs. Results are held indefinitely in IDLE.
- busy and done are never high together. busy=0 in IDLE and DONE.
- Counter width: clog2(WIDTH+1). The counter is compared against WIDTH-1 with no wrap-around. WIDTH=1 → single RUN cycle.

Test Plan:
- WIDTH=8, A=3, B=5, start pulse at E0 → busy high for 8 cycles; done pulse in the cycle after E0+8 with Sum=8, C_out=0; outputs stay at 8/0 afterwards.
- WIDTH=8, A=255, B=1 → Sum=0, C_out=1. Then A=0xAA, B=0x55 → Sum=0xFF, C_out=0. Then A=0x80, B=0x80 → Sum=0x00, C_out=1.
- Operand change and start during RUN: A=10, B=20 accepted; A/B changed to 0xFF/0xFF and start pulsed at cycles 2 and 5 of RUN → only one done; Sum=30, C_out=0; no second operation starts.
- start held high for 30 cycles with A=1, B=1 → done pulses every WIDTH+2=10 cycles, each with Sum=2, C_out=0.
- rst asserted for 1 cycle at RUN cycle 4 (A=100, B=100) → next cycle busy=0, done=0, Sum=0, C_out=0, no done pulse. A following op with A=7, B=9 gives Sum=16.
- WIDTH=1 instance, exhaustive A,B ∈ {0,1} → (0,0)→0/0, (0,1)→1/0, (1,0)→1/0, (1,1)→0/1; done pulse 2 cycles after each start edge.
